// File: rtl/dest_merge_if.sv
`default_nettype none
// ============================================================================
// Interface : dest_merge_if
// Purpose   : FIFO read ports, downstream pause and merged-stream outputs of
//             the destination merge stage.
// Revision  : 1.0
// ============================================================================
interface dest_merge_if #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
);
  logic                  D0_EMPTY;
  logic                  D1_EMPTY;
  logic                  D0_VALID;
  logic                  D1_VALID;
  logic [DATA_WIDTH-1:0] DATA_IN_D0;
  logic [DATA_WIDTH-1:0] DATA_IN_D1;
  logic                  PAUSE_IN;
  logic                  POP_D0;
  logic                  POP_D1;
  logic [DATA_WIDTH-1:0] DATA_OUT;
  logic                  VALID_OUT;
  logic                  SRC_OUT;
  logic [CNT_WIDTH-1:0]  CNT_D0;
  logic [CNT_WIDTH-1:0]  CNT_D1;
  logic [1:0]            STATE_OUT;
  logic                  ERR_OUT;

  // Merge stage side
  modport slave (
    input  D0_EMPTY, D1_EMPTY, D0_VALID, D1_VALID, DATA_IN_D0, DATA_IN_D1, PAUSE_IN,
    output POP_D0, POP_D1, DATA_OUT, VALID_OUT, SRC_OUT, CNT_D0, CNT_D1, STATE_OUT, ERR_OUT
  );

  // FIFO / link side
  modport master (
    output D0_EMPTY, D1_EMPTY, D0_VALID, D1_VALID, DATA_IN_D0, DATA_IN_D1, PAUSE_IN,
    input  POP_D0, POP_D1, DATA_OUT, VALID_OUT, SRC_OUT, CNT_D0, CNT_D1, STATE_OUT, ERR_OUT
  );
endinterface
`default_nettype wire

// File: rtl/dest_merge.sv
`default_nettype none
// ============================================================================
// Module   : dest_merge
// Purpose  : Round-robin drain of the D0/D1 destination FIFOs into one tagged
//            word stream, with pause, per-source counters and error flag.
// Revision : 1.0
// ============================================================================
module dest_merge #(
  parameter int DATA_WIDTH = 6,
  parameter int CNT_WIDTH  = 8
) (
  input  wire logic   clk,
  input  wire logic   RESET_L,
  dest_merge_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_PAUSED = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_pop0, r_pop1;
  logic                  r_pend0, r_pend1;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_src;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_data;
  logic [CNT_WIDTH-1:0]  r_cnt0, r_cnt1;
  logic                  w_elig0, w_elig1;
  logic                  w_grant0, w_grant1;
  logic                  w_last_nxt;
  logic                  w_err_now;

  // A FIFO just popped is skipped for a cycle: its empty flag has not caught up yet
  assign w_elig0   = ~bus.D0_EMPTY & ~r_pop0 & ~bus.PAUSE_IN;
  assign w_elig1   = ~bus.D1_EMPTY & ~r_pop1 & ~bus.PAUSE_IN;
  assign w_err_now = (bus.D0_VALID & ~r_pend0) | (bus.D1_VALID & ~r_pend1)
                   | (bus.D0_VALID & bus.D1_VALID);

  always_comb begin
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    w_last_nxt  = r_last;
    w_state_nxt = S_ACTIVE;
    if (w_elig0 && w_elig1) begin
      w_grant0   = r_last;
      w_grant1   = ~r_last;
      w_last_nxt = ~r_last;
    end else if (w_elig0) begin
      w_grant0 = 1'b1;
    end else if (w_elig1) begin
      w_grant1 = 1'b1;
    end
    if (bus.PAUSE_IN) begin
      w_state_nxt = S_PAUSED;
    end else if (bus.D0_EMPTY && bus.D1_EMPTY && !r_pop0 && !r_pop1 &&
                 !r_pend0 && !r_pend1 && !r_valid) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge RESET_L) begin
    if (!RESET_L) begin
      r_pop0  <= 1'b0;
      r_pop1  <= 1'b0;
      r_pend0 <= 1'b0;
      r_pend1 <= 1'b0;
      r_last  <= 1'b1;
      r_valid <= 1'b0;
      r_src   <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      r_pop0  <= w_grant0;
      r_pop1  <= w_grant1;
      r_pend0 <= r_pop0;
      r_pend1 <= r_pop1;
      r_last  <= w_last_nxt;
      r_valid <= bus.D0_VALID | bus.D1_VALID;
      r_err   <= r_err | w_err_now;
      // D0 takes priority when both valids collide; the D1 word is dropped
      if (bus.D0_VALID) begin
        r_data <= bus.DATA_IN_D0;
        r_src  <= 1'b0;
        r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      end else if (bus.D1_VALID) begin
        r_data <= bus.DATA_IN_D1;
        r_src  <= 1'b1;
        r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.POP_D0    = r_pop0;
  assign bus.POP_D1    = r_pop1;
  assign bus.DATA_OUT  = r_data;
  assign bus.VALID_OUT = r_valid;
  assign bus.SRC_OUT   = r_src;
  assign bus.CNT_D0    = r_cnt0;
  assign bus.CNT_D1    = r_cnt1;
  assign bus.STATE_OUT = r_state;
  assign bus.ERR_OUT   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dest_merge.sv
`default_nettype none
// ============================================================================
// Module   : tb_dest_merge
// Purpose  : Scoreboard bench for dest_merge with behavioural D0/D1 FIFOs.
// Revision : 1.0
// ============================================================================
module tb_dest_merge;

  typedef struct {
    int         c;
    bit         s;
    logic [5:0] d;
  } ev_t;

  logic clk = 1'b0;
  logic RESET_L;

  dest_merge_if #(.DATA_WIDTH(6), .CNT_WIDTH(8)) bus ();

  dest_merge #(.DATA_WIDTH(6), .CNT_WIDTH(8)) dut (
    .clk     (clk),
    .RESET_L (RESET_L),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  logic [5:0] q0[$], q1[$];
  logic [5:0] exp0[$], exp1[$];
  int         lat0[$], lat1[$];
  ev_t        out_log[$];
  ev_t        pop_log[$];
  bit         pend0, pend1, f0, f1;
  logic [5:0] pd0, pd1, fd0, fd1;
  int         tot0, tot1;
  int         mcnt0, mcnt1;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: per-source order, latency and running counters
  always @(negedge clk) begin
    if (!RESET_L) begin
      mcnt0 = 0;
      mcnt1 = 0;
    end else if (bus.VALID_OUT) begin
      out_log.push_back('{cyc, bus.SRC_OUT, bus.DATA_OUT});
      if (bus.SRC_OUT == 1'b0) begin
        if (exp0.size() == 0) chk("unexpected_d0_word", 1, 0);
        else begin
          chk("data_d0", bus.DATA_OUT, exp0.pop_front());
          chk("latency_d0", cyc - lat0.pop_front(), 2);
          mcnt0 = (mcnt0 + 1) % 256;
          chk("cnt_d0", bus.CNT_D0, mcnt0);
        end
      end else begin
        if (exp1.size() == 0) chk("unexpected_d1_word", 1, 0);
        else begin
          chk("data_d1", bus.DATA_OUT, exp1.pop_front());
          chk("latency_d1", cyc - lat1.pop_front(), 2);
          mcnt1 = (mcnt1 + 1) % 256;
          chk("cnt_d1", bus.CNT_D1, mcnt1);
        end
      end
    end
  end

  // One clock of the behavioural FIFOs: read data appears the cycle after a pop
  task automatic tick();
    @(negedge clk);
    bus.D0_EMPTY   = (q0.size() == 0);
    bus.D1_EMPTY   = (q1.size() == 0);
    bus.D0_VALID   = pend0 | f0;
    bus.DATA_IN_D0 = f0 ? fd0 : pd0;
    bus.D1_VALID   = pend1 | f1;
    bus.DATA_IN_D1 = f1 ? fd1 : pd1;
    f0 = 0; f1 = 0; pend0 = 0; pend1 = 0;
    if (bus.POP_D0 || bus.POP_D1) chk("pop_exclusive", bus.POP_D0 & bus.POP_D1, 0);
    if (bus.POP_D0) begin
      chk("pop_d0_when_empty", q0.size() == 0, 0);
      if (q0.size() != 0) begin
        pd0 = q0.pop_front(); pend0 = 1; lat0.push_back(cyc);
      end
      pop_log.push_back('{cyc, 1'b0, pd0});
    end
    if (bus.POP_D1) begin
      chk("pop_d1_when_empty", q1.size() == 0, 0);
      if (q1.size() != 0) begin
        pd1 = q1.pop_front(); pend1 = 1; lat1.push_back(cyc);
      end
      pop_log.push_back('{cyc, 1'b1, pd1});
    end
  endtask

  task automatic push_word(bit s, logic [5:0] d);
    if (!s) begin
      q0.push_back(d); exp0.push_back(d); bus.D0_EMPTY = 1'b0; tot0 = (tot0 + 1) % 256;
    end else begin
      q1.push_back(d); exp1.push_back(d); bus.D1_EMPTY = 1'b0; tot1 = (tot1 + 1) % 256;
    end
  endtask

  // Inject valids with no pop behind them; on collision only D0 is expected
  task automatic force_valid(bit s0, bit s1, logic [5:0] d0, logic [5:0] d1);
    f0 = s0; f1 = s1; fd0 = d0; fd1 = d1;
    if (s0) begin
      exp0.push_back(d0); lat0.push_back(cyc); tot0 = (tot0 + 1) % 256;
    end else if (s1) begin
      exp1.push_back(d1); lat1.push_back(cyc); tot1 = (tot1 + 1) % 256;
    end
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((q0.size() + q1.size() + exp0.size() + exp1.size()) != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({name, "_drained"}, q0.size() + q1.size() + exp0.size() + exp1.size(), 0);
    chk({name, "_idle"}, bus.STATE_OUT, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge
  task automatic do_reset(string name);
    @(negedge clk);
    #2;
    RESET_L = 1'b0;
    #1;
    chk({name, "_pops"}, {bus.POP_D0, bus.POP_D1}, 0);
    chk({name, "_valid_src_err"}, {bus.VALID_OUT, bus.SRC_OUT, bus.ERR_OUT}, 0);
    chk({name, "_data"}, bus.DATA_OUT, 0);
    chk({name, "_counts"}, {bus.CNT_D0, bus.CNT_D1}, 0);
    chk({name, "_state"}, bus.STATE_OUT, 0);
    q0.delete(); q1.delete(); exp0.delete(); exp1.delete();
    lat0.delete(); lat1.delete();
    pend0 = 0; pend1 = 0; f0 = 0; f1 = 0; tot0 = 0; tot1 = 0;
    bus.D0_EMPTY = 1'b1; bus.D1_EMPTY = 1'b1;
    bus.D0_VALID = 1'b0; bus.D1_VALID = 1'b0;
    bus.PAUSE_IN = 1'b0;
    repeat (2) @(negedge clk);
    RESET_L = 1'b1;
  endtask

  initial begin
    logic [5:0] alt_exp[4];
    int         vp;
    alt_exp = '{6'h01, 6'h31, 6'h02, 6'h32};
    RESET_L        = 1'b1;
    bus.D0_EMPTY   = 1'b1;
    bus.D1_EMPTY   = 1'b1;
    bus.D0_VALID   = 1'b0;
    bus.D1_VALID   = 1'b0;
    bus.DATA_IN_D0 = '0;
    bus.DATA_IN_D1 = '0;
    bus.PAUSE_IN   = 1'b0;
    pd0 = '0; pd1 = '0; fd0 = '0; fd1 = '0;
    do_reset("reset0");
    tick();

    // Single word
    pop_log.delete(); out_log.delete();
    push_word(0, 6'h15);
    drain("single");
    chk("single_pops", pop_log.size(), 1);
    chk("single_outs", out_log.size(), 1);
    chk("single_word", {out_log[0].s, out_log[0].d}, {1'b0, 6'h15});
    chk("single_latency", out_log[0].c - pop_log[0].c, 2);
    chk("single_cnt", bus.CNT_D0, 1);
    chk("single_err", bus.ERR_OUT, 0);

    // Alternation with both FIFOs loaded
    pop_log.delete(); out_log.delete();
    push_word(0, 6'h01); push_word(0, 6'h02);
    push_word(1, 6'h31); push_word(1, 6'h32);
    drain("alt");
    chk("alt_pops", pop_log.size(), 4);
    chk("alt_outs", out_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("alt_pop_src", pop_log[i].s, i % 2);
      chk("alt_pop_cycle", pop_log[i].c - pop_log[0].c, i);
      chk("alt_out_word", out_log[i].d, alt_exp[i]);
      chk("alt_out_cycle", out_log[i].c - out_log[0].c, i);
    end
    chk("alt_cnt", {bus.CNT_D0, bus.CNT_D1}, {8'd3, 8'd2});

    // Single source rate
    pop_log.delete(); out_log.delete();
    for (int i = 0; i < 4; i++) push_word(1, 6'(6'h20 + i));
    drain("rate");
    chk("rate_pops", pop_log.size(), 4);
    chk("rate_outs", out_log.size(), 4);
    for (int i = 1; i < 4; i++) chk("rate_pop_spacing", pop_log[i].c - pop_log[i-1].c, 2);

    // Pause mid-stream
    for (int i = 0; i < 6; i++) begin
      push_word(0, 6'(i));
      push_word(1, 6'(6'h10 + i));
    end
    repeat (3) tick();
    bus.PAUSE_IN = 1'b1;
    vp = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("pause_no_pop", {bus.POP_D0, bus.POP_D1}, 0);
      chk("pause_state", bus.STATE_OUT, 2);
      if (bus.VALID_OUT) vp++;
      if (i > 2) chk("pause_late_valid", bus.VALID_OUT, 0);
    end
    chk("pause_trailing_le2", vp <= 2, 1);
    bus.PAUSE_IN = 1'b0;
    drain("pause");

    // Protocol errors
    chk("err_clear_before", bus.ERR_OUT, 0);
    force_valid(0, 1, 6'h00, 6'h2A);
    tick(); tick();
    chk("err_spurious_d1", bus.ERR_OUT, 1);
    force_valid(1, 1, 6'h11, 6'h22);
    tick(); tick();
    chk("err_both_valid", bus.ERR_OUT, 1);
    chk("both_valid_word", {bus.VALID_OUT, bus.SRC_OUT, bus.DATA_OUT}, {1'b1, 1'b0, 6'h11});
    chk("both_valid_cnt_d1", bus.CNT_D1, tot1);
    chk("both_valid_cnt_d0", bus.CNT_D0, tot0);
    push_word(0, 6'h3C);
    drain("err");
    chk("err_sticky", bus.ERR_OUT, 1);
    do_reset("reset1");
    tick();

    // Randomised traffic with random pause bursts
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) push_word(1'($urandom_range(0, 1)), 6'($urandom));
      if ($urandom_range(0, 15) == 0) bus.PAUSE_IN = ~bus.PAUSE_IN;
      tick();
    end
    bus.PAUSE_IN = 1'b0;
    drain("random");
    chk("random_cnt", {bus.CNT_D0, bus.CNT_D1}, {8'(tot0), 8'(tot1)});
    chk("random_err", bus.ERR_OUT, 0);

    // Counter wrap
    do_reset("reset2");
    for (int i = 0; i < 256; i++) push_word(0, 6'(i));
    drain("wrap");
    chk("wrap_cnt_d0", bus.CNT_D0, 0);

    // Reset while words are in flight
    for (int i = 0; i < 8; i++) begin
      push_word(0, 6'(i));
      push_word(1, 6'(i + 8));
    end
    repeat (5) tick();
    do_reset("reset_mid");
    repeat (6) tick();
    chk("post_reset_state", bus.STATE_OUT, 0);
    chk("post_reset_valid", bus.VALID_OUT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
